mult_share_arbiter: RTL and testbench



---
 rtl/mult_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined multiplier among NUM_REQ clients: round-robin issue, ID-tagged response routing.
// Optional build macro MULT_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead.
module mult_share_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned MUL_LATENCY = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*XLEN-1:0]           req_mcand,
  input  logic [NUM_REQ*XLEN-1:0]           req_mplier,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                resp_valid,
  output logic [XLEN-1:0]                   resp_product,
  output logic                              mul_start,
  output logic [XLEN-1:0]                   mul_mcand,
  output logic [XLEN-1:0]                   mul_mplier,
  input  logic [XLEN-1:0]                   mul_product,
  input  logic                              mul_done,
  output logic [$clog2(MUL_LATENCY+1)-1:0]  inflight,
  output logic                              tag_err
);

  localparam int unsigned IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNTW = $clog2(MUL_LATENCY + 1);

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

  logic            gnt_any;
  logic [IDW-1:0]  gnt_id;
  tag_t            tag_q [MUL_LATENCY];
  tag_t            tail;
  logic [CNTW-1:0] settle_cnt;
  logic            settled;
  logic            complete;

`ifdef MULT_ARB_FIXED_PRIO_EN
  // Lowest valid index wins; scanning downward leaves the lowest as the final pick.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(i);
      end
    end
    if (reset) gnt_any = 1'b0;
  end
`else
  logic [IDW-1:0] ptr;
  int             idx;

  // Scan offsets from the pointer downward so the nearest valid requester is picked last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % int'(NUM_REQ);
      if (req_valid[IDW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
    if (reset) gnt_any = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end
`endif

  // Grant vector and operand mux toward the multiplier.
  always_comb begin
    req_ready  = '0;
    mul_mcand  = '0;
    mul_mplier = '0;
    mul_start  = gnt_any;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt_any && gnt_id == IDW'(i)) begin
        req_ready[i] = 1'b1;
        mul_mcand    = req_mcand[i*XLEN +: XLEN];
        mul_mplier   = req_mplier[i*XLEN +: XLEN];
      end
    end
  end

  // Requester tags travel alongside the multiplier pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(MUL_LATENCY); i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: gnt_any, id: gnt_id};
      for (int i = 1; i < int'(MUL_LATENCY); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tail     = tag_q[MUL_LATENCY-1];
  assign settled  = (settle_cnt == CNTW'(MUL_LATENCY));
  assign complete = mul_done & tail.valid;

  // Post-reset window in which stray multiplier strobes are not treated as errors.
  always_ff @(posedge clock) begin
    if (reset) begin
      settle_cnt <= '0;
    end else if (!settled) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid   <= '0;
      resp_product <= '0;
      tag_err      <= 1'b0;
      inflight     <= '0;
    end else begin
      resp_valid <= '0;
      if (complete) begin
        resp_valid[tail.id] <= 1'b1;
        resp_product        <= mul_product;
      end
      if (settled && (mul_done != tail.valid)) tag_err <= 1'b1;
      // A tag leaving the tail is no longer in flight, whether or not it completed.
      case ({gnt_any, tail.valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a behavioural 8-stage multiplier.
module tb_mult_share_arbiter;

  localparam int NR  = 4;
  localparam int XL  = 64;
  localparam int LAT = 8;

  logic             clock;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*XL-1:0] req_mcand;
  logic [NR*XL-1:0] req_mplier;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    resp_valid;
  logic [XL-1:0]    resp_product;
  logic             mul_start;
  logic [XL-1:0]    mul_mcand;
  logic [XL-1:0]    mul_mplier;
  logic [XL-1:0]    mul_product;
  logic             mul_done;
  logic [3:0]       inflight;
  logic             tag_err;
  logic             force_done;

  mult_share_arbiter #(.NUM_REQ(NR), .XLEN(XL), .MUL_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_mcand(req_mcand), .req_mplier(req_mplier),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_product(resp_product),
    .mul_start(mul_start), .mul_mcand(mul_mcand), .mul_mplier(mul_mplier),
    .mul_product(mul_product), .mul_done(mul_done),
    .inflight(inflight), .tag_err(tag_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural multiplier sharing the arbiter's reset.
  logic [XL-1:0] m_prod [LAT];
  logic          m_vld  [LAT];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin m_prod[i] <= '0; m_vld[i] <= 1'b0; end
    end else begin
      m_prod[0] <= mul_mcand * mul_mplier;
      m_vld[0]  <= mul_start;
      for (int i = 1; i < LAT; i++) begin m_prod[i] <= m_prod[i-1]; m_vld[i] <= m_vld[i-1]; end
    end
  end
  assign mul_done    = m_vld[LAT-1] | force_done;
  assign mul_product = m_prod[LAT-1];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [NR-1:0] rdy;
    logic [XL-1:0] prod;
    int            cyc;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the oldest expected entry, with LAT+1 latency.
  always @(negedge clock) begin
    if (!reset && |resp_valid) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp: got valid=%b product=%0d want none", resp_valid, resp_product);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (resp_valid !== e.rdy || resp_product !== e.prod || cyc != e.cyc + LAT + 1) begin
          bad++;
          $display("FAIL resp: got valid=%b product=%0d cycle=%0d want valid=%b product=%0d cycle=%0d",
                   resp_valid, resp_product, cyc, e.rdy, e.prod, e.cyc + LAT + 1);
        end
      end
    end
  end

  task automatic set_ops(input int i, input logic [XL-1:0] a, input logic [XL-1:0] b);
    req_mcand[i*XL +: XL]  = a;
    req_mplier[i*XL +: XL] = b;
  endtask

  // One cycle of stimulus: drive valid, check the grant, queue the hand-computed response.
  task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] exp_rdy, input logic [XL-1:0] exp_prod);
    exp_t e;
    req_valid = v;
    #1;
    chk("req_ready", XL'(req_ready), XL'(exp_rdy));
    if (exp_rdy != '0) begin
      e.rdy = exp_rdy; e.prod = exp_prod; e.cyc = cyc;
      q.push_back(e);
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    force_done = 1'b0;
    q.delete();
    #1;
    chk("ready_in_reset", XL'(req_ready), '0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_resp_valid", XL'(resp_valid), '0);
    chk("rst_product", resp_product, '0);
    chk("rst_inflight", XL'(inflight), '0);
    chk("rst_tag_err", XL'(tag_err), '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clock);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_mcand = '0;
    req_mplier = '0;
    force_done = 1'b0;
    @(negedge clock);

    // Single request from requester 2.
    do_reset();
    set_ops(2, 3, 5);
    step(4'b0100, 4'b0100, 15);
    chk("inflight_one", XL'(inflight), 1);
    idle(7);
    chk("inflight_hold", XL'(inflight), 1);
    idle(1);
    chk("inflight_back", XL'(inflight), 0);
    drain();

    do_reset();
    for (int i = 0; i < NR; i++) set_ops(i, XL'(i + 2), XL'(i + 2));
`ifndef MULT_ARB_FIXED_PRIO_EN
    // All requesters valid: rotating grants, products 4, 9, 16, 25.
    for (int r = 0; r < 2; r++) begin
      step(4'b1111, 4'b0001, 4);
      step(4'b1111, 4'b0010, 9);
      step(4'b1111, 4'b0100, 16);
      step(4'b1111, 4'b1000, 25);
    end
    chk("inflight_full", XL'(inflight), 8);
`else
    // Fixed priority: requester 0 wins every cycle.
    for (int r = 0; r < 6; r++) step(4'b1111, 4'b0001, 4);
`endif
    idle(2);
    drain();

    // Back-to-back from requester 1.
    do_reset();
    set_ops(1, 2, 2);
    step(4'b0010, 4'b0010, 4);
    set_ops(1, 3, 3);
    step(4'b0010, 4'b0010, 9);
    set_ops(1, 4, 4);
    step(4'b0010, 4'b0010, 16);
    idle(2);
    drain();

    // Reset mid-flight discards tags and returns the pointer to 0.
    do_reset();
    set_ops(0, 1, 7);
    set_ops(1, 2, 7);
    set_ops(2, 3, 7);
    step(4'b0111, 4'b0001, 7);
    step(4'b0111, 4'b0010, 14);
    step(4'b0111, 4'b0100, 21);
    idle(1);
    do_reset();
    idle(12);
    chk("midrst_inflight", XL'(inflight), 0);
    chk("midrst_tag_err", XL'(tag_err), 0);
    step(4'b1111, 4'b0001, 7);
    idle(2);
    drain();

    // Stray done inside the post-reset window is ignored; afterwards it is sticky.
    do_reset();
    idle(2);
    force_done = 1'b1;
    @(negedge clock);
    force_done = 1'b0;
    idle(1);
    chk("stray_ignored", XL'(tag_err), 0);
    idle(10);
    force_done = 1'b1;
    @(negedge clock);
    force_done = 1'b0;
    chk("tag_err_set", XL'(tag_err), 1);
    chk("err_no_resp", XL'(resp_valid), '0);
    idle(5);
    chk("tag_err_sticky", XL'(tag_err), 1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
